// File: rtl/m65_bus_wait_gen.sv
// m65_bus_wait_gen: responder side of the CPU ready handshake.
// Decodes each CPU bus request into RAM/ROM/I/O/CIA and raises bus_ready after
// a region-dependent number of wait states. Legacy CIA space first waits for
// a phi0 rising edge so that C64 I/O timing is reproduced.
// Optional feature macro: M65_WAIT_STATS_EN adds the stall_count output, a
// saturating count of cycles spent in WAIT, SYNC_PHI or HOLD.
module m65_bus_wait_gen #(
    parameter int unsigned IO_WAIT     = 2,
    parameter int unsigned ROM_WAIT    = 1,
    parameter int unsigned SLOW_HOLD   = 3,
    parameter int unsigned PHI_TIMEOUT = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [19:0] cpu_addr,
    input  logic        cpu_write,
    input  logic        cpu_ready_in,
    input  logic        phi0,
    input  logic        hypervisor_mode,
    output logic        bus_ready,
    output logic [1:0]  dev_sel,
    output logic        dev_strobe,
`ifdef M65_WAIT_STATS_EN
    output logic        phi_timeout,
    output logic [15:0] stall_count
`else
    output logic        phi_timeout
`endif
);

    localparam logic [3:0] IO_WAIT_C     = 4'(IO_WAIT);
    localparam logic [3:0] ROM_WAIT_C    = 4'(ROM_WAIT);
    localparam logic [3:0] SLOW_HOLD_C   = 4'(SLOW_HOLD);
    localparam logic [7:0] PHI_TIMEOUT_C = 8'(PHI_TIMEOUT);

    localparam logic [1:0] SEL_RAM = 2'd0;
    localparam logic [1:0] SEL_ROM = 2'd1;
    localparam logic [1:0] SEL_IO  = 2'd2;
    localparam logic [1:0] SEL_CIA = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SYNC_PHI,
        S_HOLD,
        S_READY
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  timer_q, timer_d;
    logic [1:0]  dev_sel_q, dev_sel_d;
    logic        bus_ready_q, bus_ready_d;
    logic        strobe_q, strobe_d;
    logic        timeout_q, timeout_d;
    logic        cool_q, cool_d;
    logic        last_phi0_q;

    logic        phi_rise;
    logic [11:0] page;
    logic        is_rom;
    logic        is_io;
    logic        is_cia;
    logic        unused_inputs;

    // Address bits [7:0] never affect the region and the transfer direction
    // does not change the wait-state count.
    assign unused_inputs = ^{cpu_write, cpu_addr[7:0]};

    assign page     = cpu_addr[19:8];
    assign is_rom   = (cpu_addr[19:17] == 3'b001);
    assign is_cia   = (page == 12'h0DC) || (page == 12'h0DD);
    assign is_io    = ((page >= 12'h0D0) && (page <= 12'h0DB)) ||
                      (page == 12'h0DE) || (page == 12'h0DF);
    assign phi_rise = phi0 & ~last_phi0_q;

    // phi0 history is captured every cycle, reset included, so the edge
    // detector never sees a stale level after reset is released.
    always_ff @(posedge clk) begin
        last_phi0_q <= phi0;
    end

    // Next-state logic: decode on accept, count wait states, sync CIA to phi0.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timer_d   = timer_q;
        dev_sel_d = dev_sel_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_valid && !cool_q) begin
                    timer_d = 8'd0;
                    if (is_cia && !hypervisor_mode) begin
                        dev_sel_d = SEL_CIA;
                        count_d   = 4'd0;
                        state_d   = S_SYNC_PHI;
                    end else begin
                        if (is_cia || is_io) begin
                            dev_sel_d = SEL_IO;
                            count_d   = IO_WAIT_C;
                        end else if (is_rom) begin
                            dev_sel_d = SEL_ROM;
                            count_d   = ROM_WAIT_C;
                        end else begin
                            dev_sel_d = SEL_RAM;
                            count_d   = 4'd0;
                        end
                        state_d = (count_d == 4'd0) ? S_READY : S_WAIT;
                    end
                end
            end

            S_WAIT, S_HOLD: begin
                if (!cpu_valid) begin
                    state_d = S_IDLE;
                end else if (count_q <= 4'd1) begin
                    count_d = 4'd0;
                    state_d = S_READY;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end

            S_SYNC_PHI: begin
                timer_d = timer_q + 8'd1;
                if (!cpu_valid) begin
                    state_d = S_IDLE;
                end else if (phi_rise || (timer_d == PHI_TIMEOUT_C)) begin
                    if (!phi_rise) begin
                        timeout_d = 1'b1;
                    end
                    count_d = SLOW_HOLD_C;
                    state_d = (SLOW_HOLD_C == 4'd0) ? S_READY : S_HOLD;
                end
            end

            S_READY: begin
                if (!cpu_valid || cpu_ready_in) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so that all outputs are registered;
    // a return to IDLE blocks acceptance for one cycle to keep the minimum
    // request period at three cycles.
    always_comb begin
        bus_ready_d = (state_d == S_READY);
        strobe_d    = (state_d == S_READY) && (state_q != S_READY);
        cool_d      = (state_q != S_IDLE) && (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= 4'd0;
            timer_q     <= 8'd0;
            dev_sel_q   <= SEL_RAM;
            bus_ready_q <= 1'b0;
            strobe_q    <= 1'b0;
            timeout_q   <= 1'b0;
            cool_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            dev_sel_q   <= dev_sel_d;
            bus_ready_q <= bus_ready_d;
            strobe_q    <= strobe_d;
            timeout_q   <= timeout_d;
            cool_q      <= cool_d;
        end
    end

    assign bus_ready   = bus_ready_q;
    assign dev_sel     = dev_sel_q;
    assign dev_strobe  = strobe_q;
    assign phi_timeout = timeout_q;

`ifdef M65_WAIT_STATS_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of every cycle the CPU is held off by a wait state.
    always_comb begin
        stall_d = stall_q;
        if (((state_q == S_WAIT) || (state_q == S_SYNC_PHI) || (state_q == S_HOLD)) &&
            (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_m65_bus_wait_gen.sv
// Directed testbench for m65_bus_wait_gen with default parameters
// (IO_WAIT=2, ROM_WAIT=1, SLOW_HOLD=3, PHI_TIMEOUT=80).
// Expected latency / device / timeout results are queued when a request is
// driven and compared when bus_ready appears.
module tb_m65_bus_wait_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuValid;
    logic [19:0] cpuAddr;
    logic        cpuWrite;
    logic        cpuReadyIn;
    logic        phi0;
    logic        hypervisorMode;
    logic        busReady;
    logic [1:0]  devSel;
    logic        devStrobe;
    logic        phiTimeout;
`ifdef M65_WAIT_STATS_EN
    logic [15:0] stallCount;
`endif

    typedef struct {
        string      tag;
        int         lat;
        logic [1:0] sel;
        int         toAt;
    } exp_t;

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    m65_bus_wait_gen dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_valid       (cpuValid),
        .cpu_addr        (cpuAddr),
        .cpu_write       (cpuWrite),
        .cpu_ready_in    (cpuReadyIn),
        .phi0            (phi0),
        .hypervisor_mode (hypervisorMode),
        .bus_ready       (busReady),
        .dev_sel         (devSel),
        .dev_strobe      (devStrobe),
`ifdef M65_WAIT_STATS_EN
        .phi_timeout     (phiTimeout),
        .stall_count     (stallCount)
`else
        .phi_timeout     (phiTimeout)
`endif
    );

    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and queue what the responder should do with it.
    task automatic applyStimulus(input string tag, input logic [19:0] addr, input logic wr,
                                 input logic hv, input int lat, input logic [1:0] sel,
                                 input int toAt);
        exp_t e;
        cpuAddr        = addr;
        cpuWrite       = wr;
        hypervisorMode = hv;
        cpuValid       = 1'b1;
        e.tag  = tag;
        e.lat  = lat;
        e.sel  = sel;
        e.toAt = toAt;
        sbQ.push_back(e);
    endtask

    // Wait (bounded) for bus_ready, optionally toggling phi0 on given cycles,
    // then pop the scoreboard entry and compare.
    task automatic waitReady(input int phiLowAt, input int phiHighAt, input logic releaseNow);
        exp_t e;
        int   cnt    = 0;
        int   toSeen = 0;
        e = sbQ.pop_front();
        while (cnt < 300) begin
            tick();
            cnt++;
            if (phiTimeout === 1'b1 && toSeen == 0) toSeen = cnt;
            if (busReady === 1'b1) break;
            if (cnt == phiLowAt)  phi0 = 1'b0;
            if (cnt == phiHighAt) phi0 = 1'b1;
        end
        checkOutput({e.tag, "/latency"}, cnt, e.lat);
        checkOutput({e.tag, "/dev_sel"}, {30'd0, devSel}, {30'd0, e.sel});
        checkOutput({e.tag, "/strobe"}, {31'd0, devStrobe}, 32'd1);
        checkOutput({e.tag, "/timeout_at"}, toSeen, e.toAt);
        if (releaseNow) begin
            tick();
            checkOutput({e.tag, "/release_ready"}, {31'd0, busReady}, 32'd0);
            checkOutput({e.tag, "/release_strobe"}, {31'd0, devStrobe}, 32'd0);
            cpuValid = 1'b0;
            tick();
        end
    endtask

    logic [19:0] decAddr [9];
    int          decLat  [9];
    logic [1:0]  decSel  [9];
    logic        b2bExp  [6];

    initial begin
        decAddr = '{20'h01234, 20'h20000, 20'h3FFFF, 20'h1FFFF, 20'h40000,
                    20'h0DBFF, 20'h0DE00, 20'h0DFFF, 20'h0CFFF};
        decLat  = '{1, 2, 2, 1, 1, 3, 3, 3, 1};
        decSel  = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
        b2bExp  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset          = 1'b1;
        cpuValid       = 1'b0;
        cpuAddr        = 20'h0;
        cpuWrite       = 1'b0;
        cpuReadyIn     = 1'b1;
        phi0           = 1'b0;
        hypervisorMode = 1'b0;

        // Reset state
        tick(); tick(); tick();
        checkOutput("reset/bus_ready", {31'd0, busReady}, 32'd0);
        checkOutput("reset/dev_sel", {30'd0, devSel}, 32'd0);
        checkOutput("reset/strobe", {31'd0, devStrobe}, 32'd0);
        checkOutput("reset/phi_timeout", {31'd0, phiTimeout}, 32'd0);
`ifdef M65_WAIT_STATS_EN
        checkOutput("reset/stall_count", {16'd0, stallCount}, 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Region decode and wait counts with cpu_ready_in tied high
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("decode_%05h", decAddr[i]), decAddr[i], 1'b0, 1'b0,
                          decLat[i], decSel[i], 0);
            waitReady(-1, -1, 1'b1);
        end

        // I/O write with bus_ready held while the CPU is stalled
        cpuReadyIn = 1'b0;
        applyStimulus("io_hold", 20'h0D020, 1'b1, 1'b0, 3, 2'd2, 0);
        waitReady(-1, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("io_hold/ready_%0d", i), {31'd0, busReady}, 32'd1);
            checkOutput($sformatf("io_hold/strobe_%0d", i), {31'd0, devStrobe}, 32'd0);
        end
        cpuReadyIn = 1'b1;
        tick();
        checkOutput("io_hold/drop", {31'd0, busReady}, 32'd0);
        cpuValid = 1'b0;
        tick();

        // CIA read synchronised to a phi0 edge 10 cycles after accept
        applyStimulus("cia_edge10", 20'h0DC0D, 1'b0, 1'b0, 14, 2'd3, 0);
        waitReady(-1, 10, 1'b1);
        phi0 = 1'b0;
        tick();

        // phi0 rising in the accept cycle is ignored; the next rise counts
        applyStimulus("cia_accept_edge", 20'h0DD00, 1'b0, 1'b0, 9, 2'd3, 0);
        phi0 = 1'b1;
        waitReady(2, 5, 1'b1);
        phi0 = 1'b0;
        tick();

        // Hypervisor mode treats CIA as plain I/O
        applyStimulus("cia_hv", 20'h0DC0D, 1'b0, 1'b1, 3, 2'd2, 0);
        waitReady(-1, -1, 1'b1);
        hypervisorMode = 1'b0;

        // phi0 held low: timeout after 80 SYNC_PHI cycles, then SLOW_HOLD
        applyStimulus("cia_timeout", 20'h0DC00, 1'b0, 1'b0, 84, 2'd3, 81);
        waitReady(-1, -1, 1'b1);

        // Timeout flag stays set across later requests
        applyStimulus("sticky", 20'h00010, 1'b0, 1'b0, 1, 2'd0, 1);
        waitReady(-1, -1, 1'b1);

        // Back-to-back RAM requests: period of three cycles
        cpuAddr  = 20'h01234;
        cpuValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("b2b/ready_%0d", i), {31'd0, busReady}, {31'd0, b2bExp[i]});
        end
        cpuValid = 1'b0;
        tick();
        tick();

        // Reset clears the sticky timeout flag
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("reset2/phi_timeout", {31'd0, phiTimeout}, 32'd0);
        tick();

        // Abort in WAIT
        cpuAddr  = 20'h0D020;
        cpuValid = 1'b1;
        tick();
        checkOutput("abort/wait_ready", {31'd0, busReady}, 32'd0);
        checkOutput("abort/wait_sel", {30'd0, devSel}, 32'd2);
        cpuValid = 1'b0;
        tick();
        checkOutput("abort/idle_ready", {31'd0, busReady}, 32'd0);
        tick();

        // Reset asserted while in HOLD
        cpuAddr  = 20'h0DC00;
        cpuValid = 1'b1;
        tick();
        phi0 = 1'b1;
        tick();
        checkOutput("hold/ready", {31'd0, busReady}, 32'd0);
`ifdef M65_WAIT_STATS_EN
        checkOutput("hold/stall_count", {16'd0, stallCount}, 32'd2);
`endif
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        cpuValid = 1'b0;
        checkOutput("hold_reset/ready", {31'd0, busReady}, 32'd0);
`ifdef M65_WAIT_STATS_EN
        checkOutput("hold_reset/stall_count", {16'd0, stallCount}, 32'd0);
`endif
        tick();
        checkOutput("hold_reset/ready_after", {31'd0, busReady}, 32'd0);
        tick();
        checkOutput("hold_reset/strobe_after", {31'd0, devStrobe}, 32'd0);
        phi0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
